// File: rtl/ysyx_041461_mul_ctrl.sv
// Execute-stage multiply controller: latches one M-extension op, handshakes with the multiplier, then holds the selected result.
// Optional build macro YSYX_041461_MUL_ZERO_BYPASS_EN: zero operands skip the multiplier and complete directly with 0.
module ysyx_041461_mul_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [2:0]      ex_op,
    input  logic [XLEN-1:0] ex_src1,
    input  logic [XLEN-1:0] ex_src2,
    input  logic            ex_flush,
    output logic            ex_stall,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            mul_valid_in,
    output logic            mul_flush,
    output logic            mul_mulw,
    output logic [1:0]      mul_signed,
    output logic [XLEN-1:0] mul_multiplicand,
    output logic [XLEN-1:0] mul_multiplier,
    input  logic            mul_ready,
    input  logic            mul_valid_out,
    input  logic [XLEN-1:0] mul_result_hi,
    input  logic [XLEN-1:0] mul_result_lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_MULW   = 3'b100;

    // Operand signedness {multiplicand, multiplier}; undefined encodings behave as MUL.
    function automatic logic [1:0] op_signed(input logic [2:0] op);
        logic [1:0] sgn;
        case (op)
            OP_MULHSU: sgn = 2'b10;
            OP_MULHU:  sgn = 2'b00;
            default:   sgn = 2'b11;
        endcase
        return sgn;
    endfunction

    function automatic logic op_is_word(input logic [2:0] op);
        logic w;
        case (op)
            OP_MULW: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic [XLEN-1:0] op_select(input logic [2:0]      op,
                                                  input logic [XLEN-1:0] hi,
                                                  input logic [XLEN-1:0] lo);
        logic [XLEN-1:0] res;
        case (op)
            OP_MUL:    res = lo;
            OP_MULH:   res = hi;
            OP_MULHSU: res = hi;
            OP_MULHU:  res = hi;
            OP_MULW:   res = {{(XLEN-32){lo[31]}}, lo[31:0]};
            default:   res = lo;
        endcase
        return res;
    endfunction

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [1:0]      signed_q, signed_d;
    logic            mulw_q, mulw_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_in_q, valid_in_d;
    logic            flush_q, flush_d;
    logic            out_valid_q, out_valid_d;

    logic            accept_s;
    logic            bypass_s;
    logic            capture_s;
    logic            abort_s;
    logic            zero_op_s;

    assign zero_op_s = (ex_src1 == {XLEN{1'b0}}) || (ex_src2 == {XLEN{1'b0}});

    // Next-state decode; flush is tested first in every busy state so it wins over any handshake.
    always_comb begin
        state_d   = state_q;
        accept_s  = 1'b0;
        bypass_s  = 1'b0;
        capture_s = 1'b0;
        abort_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid && !ex_flush) begin
                    accept_s = 1'b1;
`ifdef YSYX_041461_MUL_ZERO_BYPASS_EN
                    if (zero_op_s) begin
                        bypass_s = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ex_flush) begin
                    abort_s = 1'b1;
                    state_d = ST_IDLE;
                end else if (mul_ready) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_BUSY: begin
                if (ex_flush) begin
                    abort_s = 1'b1;
                    state_d = ST_IDLE;
                end else if (mul_valid_out) begin
                    capture_s = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (ex_flush || out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall EXU while an op is held, except in the cycle downstream takes the result.
    always_comb begin
        ex_stall = 1'b0;
        if (state_q == ST_IDLE) begin
            ex_stall = ex_valid && !ex_flush;
        end else begin
            ex_stall = !((state_q == ST_DONE) && out_ready);
        end
    end

    // Datapath next values: operands latch on accept, result on capture or zero bypass.
    always_comb begin
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        signed_d = signed_q;
        mulw_d   = mulw_q;
        result_d = result_q;
        if (accept_s) begin
            op_d     = ex_op;
            src1_d   = ex_src1;
            src2_d   = ex_src2;
            signed_d = op_signed(ex_op);
            mulw_d   = op_is_word(ex_op);
        end else begin
            op_d = op_q;
        end
        if (bypass_s) begin
            result_d = {XLEN{1'b0}};
        end else if (capture_s) begin
            result_d = op_select(op_q, mul_result_hi, mul_result_lo);
        end else begin
            result_d = result_q;
        end
        // Handshake outputs are registered copies of the upcoming state.
        valid_in_d  = (state_d == ST_REQ);
        out_valid_d = (state_d == ST_DONE);
        flush_d     = abort_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'b000;
            src1_q      <= {XLEN{1'b0}};
            src2_q      <= {XLEN{1'b0}};
            signed_q    <= 2'b00;
            mulw_q      <= 1'b0;
            result_q    <= {XLEN{1'b0}};
            valid_in_q  <= 1'b0;
            flush_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            signed_q    <= signed_d;
            mulw_q      <= mulw_d;
            result_q    <= result_d;
            valid_in_q  <= valid_in_d;
            flush_q     <= flush_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_result       = result_q;
    assign mul_valid_in     = valid_in_q;
    assign mul_flush        = flush_q;
    assign mul_mulw         = mulw_q;
    assign mul_signed       = signed_q;
    assign mul_multiplicand = src1_q;
    assign mul_multiplier   = src2_q;

endmodule

// File: tb/tb_ysyx_041461_mul_ctrl.sv
// Directed bench for ysyx_041461_mul_ctrl: vector table through the full request path plus flush/stall/reset sequences.
module tb_ysyx_041461_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [63:0] ex_src1, ex_src2;
    logic        ex_flush;
    logic        ex_stall;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        mul_valid_in, mul_flush, mul_mulw;
    logic [1:0]  mul_signed;
    logic [63:0] mul_multiplicand, mul_multiplier;
    logic        mul_ready, mul_valid_out;
    logic [63:0] mul_result_hi, mul_result_lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_041461_mul_ctrl #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_flush(ex_flush), .ex_stall(ex_stall),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .mul_valid_in(mul_valid_in), .mul_flush(mul_flush), .mul_mulw(mul_mulw),
        .mul_signed(mul_signed), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_ready(mul_ready),
        .mul_valid_out(mul_valid_out), .mul_result_hi(mul_result_hi),
        .mul_result_lo(mul_result_lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] hi;
        logic [63:0] lo;
        logic [1:0]  sgn;
        logic        w;
        logic [63:0] res;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2);
        ex_valid = 1'b1; ex_op = op; ex_src1 = s1; ex_src2 = s2;
        #1;
        chk("accept_stall", {63'd0, ex_stall}, 64'd1);
        tick();
        ex_valid = 1'b0; ex_src1 = 64'h0; ex_src2 = 64'h0; ex_op = 3'b000;
    endtask

    task automatic run_vec(input vec_t v);
        accept(v.op, v.s1, v.s2);
        chk("req_valid_in", {63'd0, mul_valid_in}, 64'd1);
        chk("req_signed", {62'd0, mul_signed}, {62'd0, v.sgn});
        chk("req_mulw", {63'd0, mul_mulw}, {63'd0, v.w});
        chk("req_mcand", mul_multiplicand, v.s1);
        chk("req_mplier", mul_multiplier, v.s2);
        mul_ready = 1'b1;
        tick();
        mul_ready = 1'b0;
        chk("busy_valid_in", {63'd0, mul_valid_in}, 64'd0);
        chk("busy_out_valid", {63'd0, out_valid}, 64'd0);
        mul_valid_out = 1'b1; mul_result_hi = v.hi; mul_result_lo = v.lo;
        tick();
        mul_valid_out = 1'b0; mul_result_hi = 64'hDEAD_BEEF_DEAD_BEEF; mul_result_lo = 64'h0123_4567_89AB_CDEF;
        chk("done_out_valid", {63'd0, out_valid}, 64'd1);
        chk("done_result", out_result, v.res);
        out_ready = 1'b1;
        #1;
        chk("done_ready_stall", {63'd0, ex_stall}, 64'd0);
        tick();
        out_ready = 1'b0;
        chk("after_hs_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{3'b000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1] = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b0, 64'd1};
        vecs[2] = '{3'b100, 64'h7FFF_FFFF, 64'd2, 64'd0, 64'hFFFF_FFFE, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[3] = '{3'b001, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{3'b111, 64'd5, 64'd7, 64'd0, 64'd35, 2'b11, 1'b0, 64'd35};
        vecs[6] = '{3'b100, 64'h1_0000_0003, 64'd2, 64'd0, 64'h1234_5678_0000_0006, 2'b11, 1'b1, 64'd6};

        rst = 1'b0; ex_valid = 1'b0; ex_op = 3'b000; ex_src1 = 64'h0; ex_src2 = 64'h0;
        ex_flush = 1'b0; out_ready = 1'b0; mul_ready = 1'b0; mul_valid_out = 1'b0;
        mul_result_hi = 64'h0; mul_result_lo = 64'h0;
        tick(); tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_valid_in", {63'd0, mul_valid_in}, 64'd0);
        chk("rst_flush", {63'd0, mul_flush}, 64'd0);
        chk("rst_signed", {62'd0, mul_signed}, 64'd0);
        chk("rst_mulw", {63'd0, mul_mulw}, 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_stall", {63'd0, ex_stall}, 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Flush in BUSY with a late multiplier result.
        accept(3'b000, 64'd9, 64'd9);
        mul_ready = 1'b1; tick(); mul_ready = 1'b0;
        ex_flush = 1'b1; tick(); ex_flush = 1'b0;
        mul_valid_out = 1'b1; mul_result_lo = 64'd81;
        #1;
        chk("fbusy_flush", {63'd0, mul_flush}, 64'd1);
        chk("fbusy_stall", {63'd0, ex_stall}, 64'd0);
        chk("fbusy_valid_in", {63'd0, mul_valid_in}, 64'd0);
        tick(); mul_valid_out = 1'b0;
        chk("fbusy_flush_drop", {63'd0, mul_flush}, 64'd0);
        chk("fbusy_late_ignored", {63'd0, out_valid}, 64'd0);
        tick();
        chk("fbusy_still_idle", {63'd0, out_valid}, 64'd0);

        // Flush in REQ.
        accept(3'b001, 64'd4, 64'd4);
        ex_flush = 1'b1; mul_ready = 1'b1; tick(); ex_flush = 1'b0; mul_ready = 1'b0;
        chk("freq_flush", {63'd0, mul_flush}, 64'd1);
        chk("freq_valid_in", {63'd0, mul_valid_in}, 64'd0);
        tick();
        chk("freq_flush_drop", {63'd0, mul_flush}, 64'd0);

        // mul_valid_out during REQ is ignored.
        accept(3'b000, 64'd2, 64'd3);
        mul_valid_out = 1'b1; mul_result_lo = 64'd6; tick(); mul_valid_out = 1'b0;
        chk("req_vout_ignored", {63'd0, out_valid}, 64'd0);
        chk("req_vout_hold", {63'd0, mul_valid_in}, 64'd1);
        mul_ready = 1'b1; tick(); mul_ready = 1'b0;
        mul_valid_out = 1'b1; mul_result_lo = 64'd6; mul_result_hi = 64'd0; tick(); mul_valid_out = 1'b0;
        chk("req_vout_result", out_result, 64'd6);

        // Flush in DONE beats out_ready.
        ex_flush = 1'b1; out_ready = 1'b1; tick(); ex_flush = 1'b0; out_ready = 1'b0;
        chk("fdone_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fdone_no_mulflush", {63'd0, mul_flush}, 64'd0);

        // Flush in IDLE blocks acceptance.
        ex_valid = 1'b1; ex_flush = 1'b1; ex_op = 3'b000; ex_src1 = 64'd1; ex_src2 = 64'd1;
        #1;
        chk("fidle_stall", {63'd0, ex_stall}, 64'd0);
        tick(); ex_valid = 1'b0; ex_flush = 1'b0;
        chk("fidle_no_req", {63'd0, mul_valid_in}, 64'd0);

        // MULHSU held by downstream back-pressure.
        accept(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        mul_ready = 1'b1; tick(); mul_ready = 1'b0;
        mul_valid_out = 1'b1; mul_result_hi = 64'hFFFF_FFFF_FFFF_FFFF; mul_result_lo = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(); mul_valid_out = 1'b0; mul_result_hi = 64'h0; mul_result_lo = 64'h0;
        for (int c = 0; c < 4; c++) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
            if (c == 3) out_ready = 1'b1;
            else out_ready = 1'b0;
            tick();
        end
        out_ready = 1'b0;
        chk("hold_release", {63'd0, out_valid}, 64'd0);

        // Zero operand.
`ifdef YSYX_041461_MUL_ZERO_BYPASS_EN
        accept(3'b000, 64'd12345, 64'd0);
        chk("zero_bypass_valid", {63'd0, out_valid}, 64'd1);
        chk("zero_bypass_no_req", {63'd0, mul_valid_in}, 64'd0);
        chk("zero_bypass_result", out_result, 64'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("zero_bypass_done", {63'd0, out_valid}, 64'd0);
`else
        begin
            vec_t z;
            z = '{3'b000, 64'd12345, 64'd0, 64'd0, 64'd0, 2'b11, 1'b0, 64'd0};
            run_vec(z);
        end
`endif

        // Reset mid-flight.
        accept(3'b000, 64'd7, 64'd8);
        rst = 1'b0; tick(); rst = 1'b1;
        #1;
        chk("rst2_valid_in", {63'd0, mul_valid_in}, 64'd0);
        chk("rst2_signed", {62'd0, mul_signed}, 64'd0);
        chk("rst2_mcand", mul_multiplicand, 64'd0);
        chk("rst2_flush", {63'd0, mul_flush}, 64'd0);
        chk("rst2_stall", {63'd0, ex_stall}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_041461_mul_ctrl.md
# ysyx_041461_mul_ctrl

Execute-stage controller for the M-extension multiply path. It accepts one decoded multiply op (MUL/MULH/MULHSU/MULHU/MULW) from EXU, drives the request handshake into the multiplier, and waits for its result. It selects and sign-extends the architectural result, then holds it for the downstream stage, stalling EXU while the op is in flight. It handles pipeline flush at every point of that sequence.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- ex_valid  in  1  multiply op present in EXU
- ex_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW; others treated as MUL
- ex_src1  in  64  rs1 value
- ex_src2  in  64  rs2 value
- ex_flush  in  1  kill in-flight op (redirect/exception)
- ex_stall  out  1  hold EXU
- out_valid  out  1  result available to downstream
- out_ready  in  1  downstream accepts result
- out_result  out  64  architectural rd value
- mul_valid_in  out  1  request to multiplier
- mul_flush  out  1  abort multiplier
- mul_mulw  out  1  word op
- mul_signed  out  2  [1]=multiplicand signed, [0]=multiplier signed
- mul_multiplicand  out  64  = latched src1
- mul_multiplier  out  64  = latched src2
- mul_ready  in  1  multiplier accepts request
- mul_valid_out  in  1  multiplier result valid (one cycle)
- mul_result_hi  in  64  product [127:64]
- mul_result_lo  in  64  product [63:0]

## Operation
- States: IDLE, REQ, BUSY, DONE.
- IDLE: if ex_valid & !ex_flush, latch op and operands, then go to REQ.
- REQ: mul_valid_in=1. On mul_ready=1, go to BUSY; mul_valid_in drops the next cycle.
- BUSY: on mul_valid_out=1, capture the selected result and go to DONE.
- DONE: out_valid=1. On out_ready=1, go to IDLE.
- Signedness by op:
  - MUL 11; MULH 11; MULHSU 10; MULHU 00; MULW 11 with mul_mulw=1.
- Result select by op:
  - MUL: lo.
  - MULH, MULHSU, MULHU: hi.
  - MULW: sign-extend lo[31:0] to 64 bits.
- ex_stall = (state≠IDLE & !(state==DONE & out_ready)) | (state==IDLE & ex_valid & !ex_flush).
- Flush:
  - In REQ or BUSY: mul_flush=1 for exactly one cycle, go to IDLE, result discarded.
  - In DONE: out_valid drops next cycle, go to IDLE.
  - In IDLE: the op is not accepted.
  - Flush has priority over mul_ready, mul_valid_out and out_ready in the same cycle.
- mul_valid_out while not in BUSY is ignored.
- Reset (rst=0 on a clock edge), from any state:
  - State goes to IDLE.
  - mul_valid_in, mul_flush, mul_mulw, mul_signed, out_valid, ex_stall and out_result all read 0.
  - Latched operands are cleared to 0.
  - mul_flush is not pulsed.

## Timing
- Cycle 0: IDLE accepts; ex_stall=1 combinationally.
- Cycle 1: REQ, mul_valid_in=1.
- When mul_valid_out is seen in cycle k, out_valid=1 in cycle k+1.
- Minimum latency from accept to out_valid = 2 + multiplier latency (in cycles), with mul_ready=1 on the first REQ cycle.
- out_result and out_valid are stable while out_valid=1 & out_ready=0.
- A new op may be accepted in the cycle after the out_valid/out_ready handshake; there is no back-to-back accept in the same cycle.
- All outputs except ex_stall are registered.

## Configuration
- YSYX_041461_MUL_ZERO_BYPASS_EN defined:
  - In IDLE, if ex_valid & !ex_flush & (src1==0 | src2==0), go straight to DONE with out_result=0.
  - mul_valid_in is never raised for that op.
  - out_valid=1 in cycle 1.
- Not defined: zero operands take the normal REQ/BUSY path.

## Test plan
- MUL, src1=3, src2=0xFFFFFFFFFFFFFFFE -> mul_signed=11, out_result=0xFFFFFFFFFFFFFFFA.
- MULHU, src1=0xFFFFFFFFFFFFFFFF, src2=2 -> mul_signed=00, out_result=0x1.
- MULW, src1=0x7FFFFFFF, src2=2 -> mul_mulw=1, out_result=0xFFFFFFFFFFFFFFFE.
- Flush in BUSY, with mul_valid_out arriving one cycle later:
  - mul_flush high exactly 1 cycle, state IDLE, ex_stall=0.
  - out_valid never asserted; late mul_valid_out ignored.
- MULHSU, src1=-1, src2=1, out_ready held 0 for 3 cycles:
  - out_result=0xFFFFFFFFFFFFFFFF stable for 4 cycles.
  - Single handshake, back to IDLE.
- Zero operand, src2=0:
  - Macro defined: out_valid=1 in cycle 1, mul_valid_in stays 0.
  - Macro undefined: full request path, out_result=0.
